dm_cache_ctrl: RTL

// - Direct-mapped, write-back, write-allocate cache controller between CPU load/store port and main_memory.
// - One 32-bit word per line; tag/valid/dirty/data arrays in registers.
// - Drives main_memory's addr/write_data/memwrite/memread; consumes its registered read_data (1-cycle latency).

---
 rtl/dm_cache_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller with one word per line.
// Optional hit/miss/writeback statistics counters are built when CACHE_STATS_EN is defined.
module dm_cache_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int INDEX_BITS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_memwrite,
    output logic              mem_memread,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count,
    output logic [15:0]       wb_count
);

    // state      | meaning
    // IDLE       | waiting for a request; latches addr/we/wdata
    // COMPARE    | tag check; hits complete here, misses pick a path
    // WRITEBACK  | dirty victim being written (memwrite high this cycle)
    // ALLOCATE   | refill read issued (memread high this cycle)
    // ALLOC_WAIT | refill data returned; line installed, re-compare next

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - INDEX_BITS;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE,
        ALLOC_WAIT
    } state_t;

    state_t              state;
    logic                req_we;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [LINES-1:0]    valid;
    logic [LINES-1:0]    dirty;
    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [DATA_W-1:0]   data_mem [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      req_tag;
    logic                  hit;

    assign idx     = req_addr[INDEX_BITS-1:0];
    assign req_tag = req_addr[ADDR_W-1:INDEX_BITS];
    assign hit     = valid[idx] && (tag_mem[idx] == req_tag);

    // Strobes are set on the transition into WRITEBACK/ALLOCATE so that they
    // are high during those states and refill data is ready in ALLOC_WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            req_we         <= 1'b0;
            req_addr       <= '0;
            req_wdata      <= '0;
            valid          <= '0;
            dirty          <= '0;
            cpu_ready      <= 1'b0;
            cpu_rdata      <= '0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_memwrite   <= 1'b0;
            mem_memread    <= 1'b0;
        end else begin
            cpu_ready    <= 1'b0;
            mem_memwrite <= 1'b0;
            mem_memread  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req && !cpu_ready) begin
                        req_we    <= cpu_we;
                        req_addr  <= cpu_addr;
                        req_wdata <= cpu_wdata;
                        state     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        if (req_we) begin
                            data_mem[idx] <= req_wdata;
                            dirty[idx]    <= 1'b1;
                        end else begin
                            cpu_rdata <= data_mem[idx];
                        end
                        cpu_ready <= 1'b1;
                        state     <= IDLE;
                    end else if (valid[idx] && dirty[idx]) begin
                        mem_addr       <= {tag_mem[idx], idx};
                        mem_write_data <= data_mem[idx];
                        mem_memwrite   <= 1'b1;
                        state          <= WRITEBACK;
                    end else begin
                        mem_addr    <= req_addr;
                        mem_memread <= 1'b1;
                        state       <= ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    dirty[idx]  <= 1'b0;
                    mem_addr    <= req_addr;
                    mem_memread <= 1'b1;
                    state       <= ALLOCATE;
                end
                ALLOCATE: begin
                    state <= ALLOC_WAIT;
                end
                ALLOC_WAIT: begin
                    data_mem[idx] <= mem_read_data;
                    tag_mem[idx]  <= req_tag;
                    valid[idx]    <= 1'b1;
                    dirty[idx]    <= 1'b0;
                    state         <= COMPARE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic refill;
    logic hit_evt;
    logic miss_evt;
    logic wb_evt;

    assign hit_evt  = (state == COMPARE) && hit && !refill;
    assign miss_evt = (state == COMPARE) && !hit;
    assign wb_evt   = (state == WRITEBACK);

    // refill marks the re-compare that follows a line install
    always_ff @(posedge clk) begin
        if (rst) begin
            refill     <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (state == ALLOC_WAIT) begin
                refill <= 1'b1;
            end else if (state == COMPARE) begin
                refill <= 1'b0;
            end
            if (hit_evt && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'd1;
            end
            if (miss_evt && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
            if (wb_evt && (wb_count != 16'hFFFF)) begin
                wb_count <= wb_count + 16'd1;
            end
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

endmodule
